// File: rtl/irq_stack_ctrl_pkg.sv
// Shared defaults and mode encodings for the interrupt/stack controller.
package irq_stack_ctrl_pkg;

  localparam int             DEF_N_IRQ      = 4;
  localparam int             DEF_AW         = 10;
  localparam logic [9:0]     DEF_VEC_BASE   = 10'h3C0;
  localparam int             DEF_VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ISR   = 2'd1,
    FAULT = 2'd2
  } mode_t;

endpackage

// File: rtl/irq_stack_ctrl_if.sv
// Return-address stack bus: the controller is the master, the stack the slave.
interface irq_stack_ctrl_if #(
  parameter int AW = irq_stack_ctrl_pkg::DEF_AW
);
  logic          stack_push;
  logic          stack_pop;
  logic          stack_interrupt;
  logic [AW-1:0] stack_addr;
  logic          stack_overflow;
  logic          stack_underflow;

  modport master (
    output stack_push, stack_pop, stack_interrupt, stack_addr,
    input  stack_overflow, stack_underflow
  );

  modport slave (
    input  stack_push, stack_pop, stack_interrupt, stack_addr,
    output stack_overflow, stack_underflow
  );
endinterface

// File: rtl/irq_stack_ctrl_prio_enc.sv
// Lowest-index priority encoder: valid plus index of the lowest set bit.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_stack_ctrl.sv
// Arbitrates decoder call/ret/reti against prioritised, nestable interrupts
// and drives the return-address stack.
module irq_stack_ctrl
  import irq_stack_ctrl_pkg::*;
#(
  parameter int            N_IRQ      = DEF_N_IRQ,
  parameter int            AW         = DEF_AW,
  parameter logic [AW-1:0] VEC_BASE   = AW'(DEF_VEC_BASE),
  parameter int            VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              cpu_push,
  input  logic              cpu_pop,
  input  logic              cpu_reti,
  input  logic              cpu_ei,
  input  logic              cpu_di,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  input  logic [AW-1:0]     pc,
  irq_stack_ctrl_if.master  stk,
  output logic              take,
  output logic [AW-1:0]     vector,
  output logic [N_IRQ-1:0]  in_service,
  output logic [N_IRQ-1:0]  pending,
  output logic              fault
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // The last vector must fit in the address space.
  if (int'(VEC_BASE) + (N_IRQ - 1) * VEC_STRIDE >= 2 ** AW) begin : g_vec_chk
    $error("irq_stack_ctrl: vector table exceeds address width");
  end

  mode_t            mode, mode_nx;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] mask, mask_nx;
  logic             gie, gie_nx;
  logic [N_IRQ-1:0] pending_nx, in_service_nx;
  logic [N_IRQ-1:0] edge_det, lim, eligible, sel_onehot, isr_onehot;
  logic [IW-1:0]    sel_idx, isr_idx;
  logic             isr_valid, reti_eff, can_take;

  assign fault = (mode == FAULT);

  irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_sel_enc (
    .req   (eligible),
    .valid (take),
    .idx   (sel_idx)
  );

  irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_isr_enc (
    .req   (in_service),
    .valid (isr_valid),
    .idx   (isr_idx)
  );

  // Eligibility: only lines strictly above the active level may preempt.
  always_comb begin
    lim = '1;
    if (mode == ISR) begin
      for (int i = 0; i < N_IRQ; i++) lim[i] = (i < int'(isr_idx));
    end
    can_take = gie & ~fault & ~cpu_reti;
    eligible = pending & mask & lim & {N_IRQ{can_take}};
  end

  // Stack drive and vector; a take overrides whatever the decoder issued.
  always_comb begin
    stk.stack_addr = pc;
    if (take) begin
      stk.stack_push      = 1'b1;
      stk.stack_pop       = 1'b0;
      stk.stack_interrupt = 1'b0;
      vector = AW'(VEC_BASE + AW'(sel_idx) * AW'(VEC_STRIDE));
    end else begin
      stk.stack_push      = cpu_push;
      stk.stack_pop       = ~cpu_push & (cpu_pop | cpu_reti);
      stk.stack_interrupt = ~cpu_push & cpu_reti;
      vector = '0;
    end
  end

  // Next-state: edge latch, take/reti bookkeeping, enables and mode.
  always_comb begin
    edge_det   = irq & ~irq_prev;
    sel_onehot = take ? (N_IRQ'(1) << sel_idx) : '0;
    reti_eff   = cpu_reti & ~cpu_push & ~take;
    isr_onehot = (reti_eff && isr_valid) ? (N_IRQ'(1) << isr_idx) : '0;

    pending_nx    = (pending & ~sel_onehot) | edge_det;
    in_service_nx = (in_service & ~isr_onehot) | sel_onehot;
    mask_nx       = mask_we ? mask_wdata : mask;
    gie_nx        = cpu_di ? 1'b0 : (cpu_ei ? 1'b1 : gie);

    mode_nx = RUN;
    if (fault || stk.stack_overflow || stk.stack_underflow) mode_nx = FAULT;
    else if (in_service_nx != '0)                            mode_nx = ISR;
  end

  // Controller state; a line held high through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode       <= RUN;
      irq_prev   <= '1;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
      gie        <= 1'b0;
    end else begin
      mode       <= mode_nx;
      irq_prev   <= irq;
      pending    <= pending_nx;
      in_service <= in_service_nx;
      mask       <= mask_nx;
      gie        <= gie_nx;
    end
  end

endmodule

// File: tb/tb_irq_stack_ctrl.sv
// Directed bench for irq_stack_ctrl with hand-computed expectations.
module tb_irq_stack_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        cpu_push, cpu_pop, cpu_reti, cpu_ei, cpu_di, mask_we;
  logic [3:0]  mask_wdata;
  logic [9:0]  pc;
  logic        take, fault;
  logic [9:0]  vector;
  logic [3:0]  in_service, pending;

  int n_chk  = 0;
  int n_pass = 0;

  irq_stack_ctrl_if #(.AW(10)) stk ();

  irq_stack_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .cpu_push   (cpu_push),
    .cpu_pop    (cpu_pop),
    .cpu_reti   (cpu_reti),
    .cpu_ei     (cpu_ei),
    .cpu_di     (cpu_di),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pc         (pc),
    .stk        (stk.master),
    .take       (take),
    .vector     (vector),
    .in_service (in_service),
    .pending    (pending),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_push = 0; cpu_pop = 0; cpu_reti = 0; cpu_ei = 0; cpu_di = 0;
    mask_we = 0; mask_wdata = 4'h0;
  endtask

  // One reti cycle followed by the clearing edge.
  task automatic do_reti();
    cpu_reti = 1;
    cyc();
    cpu_reti = 0;
    #1;
  endtask

  initial begin
    reset = 0; irq = 4'h0; pc = 10'h000; idle();
    stk.stack_overflow = 0; stk.stack_underflow = 0;
    cyc(); cyc();
    reset = 1;
    #1;
    chk("rst_take", take, 0);
    chk("rst_pending", pending, 4'h0);
    chk("rst_in_service", in_service, 4'h0);
    chk("rst_fault", fault, 0);
    chk("rst_vector", vector, 10'h000);
    chk("rst_push", stk.stack_push, 0);

    // Basic take and return
    mask_we = 1; mask_wdata = 4'hF; cpu_ei = 1;
    cyc(); idle();
    irq = 4'b0100; pc = 10'h055;
    #1;
    chk("b_no_take_yet", take, 0);
    cyc();
    chk("b_take", take, 1);
    chk("b_vector", vector, 10'h3C8);
    chk("b_push", stk.stack_push, 1);
    chk("b_addr", stk.stack_addr, 10'h055);
    chk("b_pop", stk.stack_pop, 0);
    cyc();
    chk("b_in_service", in_service, 4'b0100);
    chk("b_pending_clr", pending, 4'h0);
    chk("b_take_off", take, 0);
    irq = 4'h0; cpu_reti = 1;
    #1;
    chk("b_reti_pop", stk.stack_pop, 1);
    chk("b_reti_int", stk.stack_interrupt, 1);
    cyc(); cpu_reti = 0; #1;
    chk("b_isr_done", in_service, 4'h0);

    // Priority and preemption
    irq = 4'b1010;
    cyc();
    chk("p_take1", take, 1);
    chk("p_vec1", vector, 10'h3C4);
    cyc();
    chk("p_is1", in_service, 4'b0010);
    chk("p_pend3", pending, 4'b1000);
    chk("p_no3", take, 0);
    irq = 4'b1011;
    cyc();
    chk("p_take0", take, 1);
    chk("p_vec0", vector, 10'h3C0);
    cyc();
    chk("p_is01", in_service, 4'b0011);
    irq = 4'b1111;
    cyc();
    chk("p_pend23", pending, 4'b1100);
    chk("p_no2", take, 0);
    do_reti();
    chk("p_is_after1", in_service, 4'b0010);
    chk("p_no2b", take, 0);
    do_reti();
    chk("p_is_after2", in_service, 4'b0000);
    chk("p_take2", take, 1);
    chk("p_vec2", vector, 10'h3C8);
    cyc();
    chk("p_is2", in_service, 4'b0100);
    chk("p_no3b", take, 0);
    do_reti();
    chk("p_vec3", vector, 10'h3CC);
    cyc();
    chk("p_is3", in_service, 4'b1000);
    do_reti();
    chk("p_all_done", in_service, 4'h0);
    irq = 4'h0;

    // Gating by gie and mask
    cpu_di = 1; cpu_ei = 1;
    cyc(); idle();
    irq = 4'b0010;
    cyc();
    chk("g_pend", pending, 4'b0010);
    chk("g_gie_off", take, 0);
    cyc();
    chk("g_gie_off2", take, 0);
    cpu_ei = 1; mask_we = 1; mask_wdata = 4'b1101;
    cyc(); idle();
    chk("g_mask_off", take, 0);
    chk("g_pend2", pending, 4'b0010);
    mask_we = 1; mask_wdata = 4'b1111;
    #1;
    chk("g_old_mask", take, 0);
    cyc(); idle();
    chk("g_take", take, 1);
    chk("g_vec", vector, 10'h3C4);
    cyc();
    do_reti();
    irq = 4'h0;

    // Conflicts
    cpu_push = 1; cpu_pop = 1;
    #1;
    chk("c_push_wins", stk.stack_push, 1);
    chk("c_pop_lost", stk.stack_pop, 0);
    idle();
    irq = 4'b0001;
    cyc();
    cpu_push = 1; pc = 10'h0AA;
    #1;
    chk("c_take", take, 1);
    chk("c_push", stk.stack_push, 1);
    chk("c_addr", stk.stack_addr, 10'h0AA);
    chk("c_nopop", stk.stack_pop, 0);
    cyc(); cpu_push = 0;
    chk("c_is0", in_service, 4'b0001);
    do_reti();
    irq = 4'h0;
    cyc();
    irq = 4'b0100;
    cyc();
    cpu_reti = 1;
    #1;
    chk("c_reti_notake", take, 0);
    chk("c_reti_pop", stk.stack_pop, 1);
    chk("c_reti_nopush", stk.stack_push, 0);
    cyc(); cpu_reti = 0; #1;
    chk("c_take_later", take, 1);
    chk("c_vec_later", vector, 10'h3C8);
    cyc();
    do_reti();
    irq = 4'h0;

    // Fault
    stk.stack_overflow = 1;
    cyc();
    stk.stack_overflow = 0;
    chk("f_fault", fault, 1);
    irq = 4'b0001;
    cyc();
    chk("f_pend0", pending, 4'b0001);
    chk("f_notake", take, 0);
    cpu_push = 1;
    #1;
    chk("f_push_pass", stk.stack_push, 1);
    cpu_push = 0;
    cyc();
    chk("f_sticky", fault, 1);

    // Reset with irq[3] held high across release
    irq = 4'b1000; reset = 0;
    cyc();
    reset = 1;
    cyc();
    chk("r_fault_clr", fault, 0);
    chk("r_pend_clr", pending, 4'h0);
    chk("r_is_clr", in_service, 4'h0);
    cyc();
    chk("r_no_edge", pending, 4'h0);
    irq = 4'h0;
    cyc();
    irq = 4'b1000;
    cyc();
    chk("r_edge", pending, 4'b1000);
    chk("r_masked", take, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete (checks %0d)", n_chk);
    $fatal(1, "timeout");
  end

endmodule
